// File: rtl/exstage_pipe.sv
// exstage_pipe: registered rv32i execute stage.
// Computes the ALU result for one decoded operation and holds it in an
// EX/MEM output register behind a valid/ready handshake. Supports flush.
// Optional feature macro: EXSTAGE_SERIAL_SHIFT_EN selects a multi-cycle
// serial shifter; without it shifts use a single-cycle barrel shifter.
//
// Handshake: an operation transfers in at a rising edge when
// valid_i && ready_o, and a result transfers out when valid_o && ready_i.
// While valid_o && !ready_i the result and rd are held stable. flush_i
// overrides both transfers for that cycle.
module exstage_pipe #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [2:0]         alu_op_i,
    input  logic               alu_alt_op_i,
    input  logic [XLEN-1:0]    operand1_i,
    input  logic [XLEN-1:0]    operand2_i,
    input  logic [RADDR_W-1:0] rd_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [XLEN-1:0]    result_o,
    output logic [RADDR_W-1:0] rd_o,
    output logic               busy_o,
    output logic               dbg_state_o
);

    localparam int SHW = $clog2(XLEN);

    logic               r_valid;
    logic [XLEN-1:0]    r_result;
    logic [RADDR_W-1:0] r_rd;

    logic [SHW-1:0]     w_shamt;
    logic [XLEN-1:0]    w_sra;
    logic [XLEN-1:0]    w_alu_result;
    logic               w_accept;
    logic               w_consume;

    assign w_shamt   = operand2_i[SHW-1:0];
    assign w_sra     = $signed(operand1_i) >>> w_shamt;
    assign w_accept  = valid_i && ready_o;
    assign w_consume = r_valid && ready_i;

    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign rd_o     = r_rd;

    // Single-cycle ALU: every op, including the barrel-shift path.
    always_comb begin
        w_alu_result = '0;
        case (alu_op_i)
            3'b000:  w_alu_result = alu_alt_op_i ? (operand1_i - operand2_i)
                                                 : (operand1_i + operand2_i);
            3'b001:  w_alu_result = operand1_i << w_shamt;
            3'b010:  w_alu_result = {{(XLEN-1){1'b0}},
                                     ($signed(operand1_i) < $signed(operand2_i))};
            3'b011:  w_alu_result = {{(XLEN-1){1'b0}}, (operand1_i < operand2_i)};
            3'b100:  w_alu_result = operand1_i ^ operand2_i;
            3'b101:  w_alu_result = alu_alt_op_i ? w_sra : (operand1_i >> w_shamt);
            3'b110:  w_alu_result = operand1_i | operand2_i;
            default: w_alu_result = operand1_i & operand2_i;
        endcase
    end

`ifdef EXSTAGE_SERIAL_SHIFT_EN

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic [XLEN-1:0]    r_sh_data;
    logic [SHW-1:0]     r_sh_cnt;
    logic               r_sh_left;
    logic               r_sh_arith;
    logic [RADDR_W-1:0] r_sh_rd;

    logic               w_start_shift;
    logic [XLEN-1:0]    w_sh_next;

    // Ops 001 and 101 are the shifts; a zero shamt takes the single-cycle path.
    assign w_start_shift = w_accept && (alu_op_i[1:0] == 2'b01) && (w_shamt != '0);
    assign w_sh_next     = r_sh_left ? {r_sh_data[XLEN-2:0], 1'b0}
                                     : {(r_sh_arith & r_sh_data[XLEN-1]), r_sh_data[XLEN-1:1]};

    assign ready_o     = !flush_i && (r_state == S_IDLE) && (!r_valid || ready_i);
    assign busy_o      = r_busy;
    assign dbg_state_o = r_state;

    // Output register plus serial shift FSM; the output register is always
    // free when the shift completes, so completion never waits on ready_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_rd       <= '0;
            r_sh_data  <= '0;
            r_sh_cnt   <= '0;
            r_sh_left  <= 1'b0;
            r_sh_arith <= 1'b0;
            r_sh_rd    <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_shift) begin
                        r_sh_data  <= operand1_i;
                        r_sh_cnt   <= w_shamt;
                        r_sh_left  <= ~alu_op_i[2];
                        r_sh_arith <= alu_alt_op_i;
                        r_sh_rd    <= rd_i;
                        r_busy     <= 1'b1;
                        r_valid    <= 1'b0;
                        r_state    <= S_SHIFT;
                    end else if (w_accept) begin
                        r_result <= w_alu_result;
                        r_rd     <= rd_i;
                        r_valid  <= 1'b1;
                    end else if (w_consume) begin
                        r_valid <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_sh_data <= w_sh_next;
                    if (r_sh_cnt == SHW'(1)) begin
                        r_result <= w_sh_next;
                        r_rd     <= r_sh_rd;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_sh_cnt <= r_sh_cnt - SHW'(1);
                    end
                end
            endcase
        end
    end

`else

    assign ready_o     = !flush_i && (!r_valid || ready_i);
    assign busy_o      = 1'b0;
    assign dbg_state_o = 1'b0;

    // Output register: load on accept, clear on consume, clear on flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_result <= w_alu_result;
            r_rd     <= rd_i;
            r_valid  <= 1'b1;
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_exstage_pipe.sv
// Self-checking bench for exstage_pipe: directed cases plus randomized
// traffic, with a queue-based scoreboard checked by an independent monitor.
module tb_exstage_pipe;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int EW      = 32 + 8 + RADDR_W + XLEN;
`ifdef EXSTAGE_SERIAL_SHIFT_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_ni = 1'b0;
  logic               flush_i = 1'b0;
  logic               valid_i = 1'b0;
  logic               ready_o;
  logic [2:0]         alu_op_i = '0;
  logic               alu_alt_op_i = 1'b0;
  logic [XLEN-1:0]    operand1_i = '0;
  logic [XLEN-1:0]    operand2_i = '0;
  logic [RADDR_W-1:0] rd_i = '0;
  logic               valid_o;
  logic               ready_i = 1'b0;
  logic [XLEN-1:0]    result_o;
  logic [RADDR_W-1:0] rd_o;
  logic               busy_o;
  logic               dbg_state_o;

  exstage_pipe #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .alu_op_i     (alu_op_i),
    .alu_alt_op_i (alu_alt_op_i),
    .operand1_i   (operand1_i),
    .operand2_i   (operand2_i),
    .rd_i         (rd_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .result_o     (result_o),
    .rd_o         (rd_o),
    .busy_o       (busy_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];   // {accept cycle, latency, rd, result}
  int sh_start = 0;
  int sh_end   = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference ALU from the op-code table, plain arithmetic.
  function automatic logic [XLEN-1:0] ref_alu(input logic [2:0] op, input logic alt,
                                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int sh;
    logic [XLEN-1:0] ones;
    logic [XLEN-1:0] fill;
    sh   = int'(b[4:0]);
    ones = '1;
    fill = '0;
    case (op)
      3'd0: return alt ? (a - b) : (a + b);
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (alt && a[XLEN-1]) fill = ~(ones >> sh);
        return (a >> sh) | fill;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [XLEN-1:0] b);
    int sh;
    sh = int'(b[4:0]);
    if (SERIAL && (op == 3'd1 || op == 3'd5) && sh != 0) return sh + 1;
    return 1;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with inputs driven; samples acceptance at negedge.
  task automatic cycle_step(input logic use_model, input logic [XLEN-1:0] exp_res, output logic acc);
    int lat;
    logic [XLEN-1:0] r;
    @(negedge clk);
    acc = 1'b0;
    if (flush_i) check("flush_ready", ready_o, 0);
    if (rst_ni && valid_i && ready_o) begin
      acc = 1'b1;
      lat = ref_lat(alu_op_i, operand2_i);
      r   = use_model ? ref_alu(alu_op_i, alu_alt_op_i, operand1_i, operand2_i) : exp_res;
      exp_q.push_back({32'(cyc), 8'(lat), rd_i, r});
      if (lat > 1) begin
        sh_start = cyc;
        sh_end   = cyc + lat;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic alt, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [RADDR_W-1:0] rd,
                       input logic use_model, input logic [XLEN-1:0] exp_res);
    logic acc;
    int n;
    alu_op_i = op; alu_alt_op_i = alt; operand1_i = a; operand2_i = b; rd_i = rd;
    valid_i = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 300) begin
      cycle_step(use_model, exp_res, acc);
      n++;
    end
    if (!acc) begin
      failures++;
      $display("FAIL issue_timeout: actual=not accepted required=accepted within 300 cycles");
    end
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    valid_i = 1'b0;
    ready_i = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic p_vo, p_cons, p_fl, is_new;
    logic [XLEN-1:0] p_res;
    logic [RADDR_W-1:0] p_rd;
    logic [EW-1:0] e;
    p_vo = 0; p_cons = 0; p_fl = 0; p_res = '0; p_rd = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        p_vo = 0; p_cons = 0; p_fl = 0;
      end else begin
        check("busy_o", busy_o, (cyc > sh_start && cyc < sh_end) ? 1 : 0);
        if (p_vo && !p_cons && !p_fl) begin
          check("hold_valid", valid_o, 1);
          check("hold_result", result_o, p_res);
          check("hold_rd", rd_o, p_rd);
        end
        is_new = valid_o && (!p_vo || p_cons || p_fl);
        if (is_new) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output: actual result=0x%0h rd=%0d required=no output", result_o, rd_o);
          end else begin
            e = exp_q[0];
            check("latency", 32'(cyc) - e[EW-1:EW-32], 32'(e[XLEN+RADDR_W+7:XLEN+RADDR_W]));
          end
        end
        if (flush_i) begin
          exp_q.delete();
          if (sh_end > cyc + 1) sh_end = cyc + 1;
        end else if (valid_o && ready_i && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result", result_o, e[XLEN-1:0]);
          check("rd", rd_o, e[XLEN+RADDR_W-1:XLEN]);
        end
        p_vo = valid_o; p_cons = valid_o && ready_i; p_fl = flush_i;
        p_res = result_o; p_rd = rd_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [XLEN-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic acc;
    // Reset values while held in reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_rd", rd_o, 0);
    check("rst_busy", busy_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b1;

    // Op coverage with values fixed by hand.
    issue(3'd0, 1'b0, 32'h7FFF_FFFF, 32'h1, 5'd1, 1'b0, 32'h8000_0000);
    issue(3'd0, 1'b1, 32'h0, 32'h1, 5'd2, 1'b0, 32'hFFFF_FFFF);
    issue(3'd2, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd3, 1'b0, 32'h1);
    issue(3'd3, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd4, 1'b0, 32'h0);
    issue(3'd5, 1'b1, 32'h8000_0000, 32'h4, 5'd6, 1'b0, 32'hF800_0000);
    issue(3'd1, 1'b0, 32'h1, 32'h21, 5'd7, 1'b0, 32'h2);
    issue(3'd0, 1'b0, 32'h3, 32'h4, 5'd0, 1'b0, 32'h7);
    drain();

    // Back-pressure: second op must wait, first result held.
    ready_i = 1'b0;
    issue(3'd0, 1'b0, 32'd10, 32'd20, 5'd9, 1'b1, '0);
    alu_op_i = 3'd4; alu_alt_op_i = 1'b0; operand1_i = 32'hA5A5_0F0F; operand2_i = 32'hFFFF_0000; rd_i = 5'd10;
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", ready_o, 0);
      @(posedge clk);
      #1;
    end
    ready_i = 1'b1;
    issue(3'd4, 1'b0, 32'hA5A5_0F0F, 32'hFFFF_0000, 5'd10, 1'b1, '0);
    drain();

    // Streaming: 8 ADDs back to back.
    ready_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alu_op_i = 3'd0; alu_alt_op_i = 1'b0;
      operand1_i = 32'(i * 3 + 1); operand2_i = 32'd100; rd_i = 5'(i + 1);
      cycle_step(1'b1, '0, acc);
      check("stream_accept", acc, 1);
    end
    drain();

    // Shifts: long shift and zero-shamt shift.
    issue(3'd1, 1'b0, 32'h1, 32'd31, 5'd5, 1'b0, 32'h8000_0000);
    drain();
    issue(3'd5, 1'b0, 32'h0000_00F0, 32'd0, 5'd8, 1'b0, 32'h0000_00F0);
    drain();

    // Flush while the output register holds a result.
    ready_i = 1'b0;
    issue(3'd6, 1'b0, 32'h0F00, 32'h00F0, 5'd10, 1'b1, '0);
    flush_i = 1'b1;
    alu_op_i = 3'd0; operand1_i = 32'd1; operand2_i = 32'd2; rd_i = 5'd11;
    valid_i = 1'b1;
    cycle_step(1'b1, '0, acc);
    check("flush_accept", acc, 0);
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    check("flush_valid", valid_o, 0);
    check("flush_state", dbg_state_o, 0);
    @(posedge clk);
    #1;

    // Flush during a shift.
    ready_i = 1'b1;
    issue(3'd1, 1'b0, 32'h3, 32'd10, 5'd11, 1'b1, '0);
    flush_i = 1'b1;
    alu_op_i = 3'd0; operand1_i = 32'd5; operand2_i = 32'd6; rd_i = 5'd12;
    valid_i = 1'b1;
    cycle_step(1'b1, '0, acc);
    check("flush2_accept", acc, 0);
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    check("flush2_valid", valid_o, 0);
    check("flush2_busy", busy_o, 0);
    check("flush2_state", dbg_state_o, 0);
    @(posedge clk);
    #1;
    issue(3'd7, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd13, 1'b1, '0);
    drain();

    // Reset during activity.
    ready_i = 1'b1;
    issue(3'd1, 1'b0, 32'h5, 32'd20, 5'd12, 1'b1, '0);
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_result", result_o, 0);
    check("arst_rd", rd_o, 0);
    check("arst_busy", busy_o, 0);
    exp_q.delete();
    sh_end = 0;
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_ni = 1'b1;
    #1;
    check("arst_ready", ready_o, 1);
    @(posedge clk);
    #1;

    // Randomized traffic with back-pressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      valid_i      = ($urandom_range(0, 3) != 0);
      ready_i      = ($urandom_range(0, 3) != 0);
      flush_i      = ($urandom_range(0, 24) == 0);
      alu_op_i     = 3'($urandom_range(0, 7));
      alu_alt_op_i = 1'($urandom_range(0, 1));
      operand1_i   = rand_operand();
      operand2_i   = rand_operand();
      rd_i         = 5'($urandom_range(0, 31));
      cycle_step(1'b1, '0, acc);
    end
    flush_i = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/exstage_pipe.md
# exstage_pipe

Parametrised, registered execute stage for the rv32i core. Takes a decoded ALU operation (funct3 encoding plus alternate-op bit), two operands and a destination register index. It computes the result and holds it in an EX/MEM output register behind a valid/ready handshake. Supports pipeline flush and, optionally, a multi-cycle serial shifter. It sits between the decode stage and the memory stage.

## Interface
- `XLEN`, default 32: operand and result width; power of two, ≥ 8.
- `RADDR_W`, default 5: destination register index width.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: discard the output register and any in-flight operation.
- `valid_i` in 1: upstream offers an operation.
- `ready_o` out 1: stage accepts an operation this cycle.
- `alu_op_i` in 3: funct3 operation code.
- `alu_alt_op_i` in 1: selects SUB over ADD and SRA over SRL; ignored for other ops.
- `operand1_i`, `operand2_i` in XLEN: operands.
- `rd_i` in RADDR_W: destination register index.
- `valid_o` out 1: output register holds a result.
- `ready_i` in 1: downstream accepts the result.
- `result_o` out XLEN: registered result.
- `rd_o` out RADDR_W: registered destination index.
- `busy_o` out 1: a serial shift is in progress.

## Operation
- Op codes:
  - 000: ADD, or SUB when alt = 1.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when alt = 1.
  - 110: OR.
  - 111: AND.
- Shift amount is `operand2_i[log2(XLEN)-1:0]`; upper bits are ignored.
- Add, subtract and shift results wrap modulo 2^XLEN.
- SLT and SLTU return zero-extended 0 or 1.
- Accept condition: `valid_i && ready_o`.
- `ready_o = !flush_i && state==IDLE && (!valid_o || ready_i)`; combinational.
- On accept of a single-cycle op, `result_o`, `rd_o` and `valid_o`=1 are loaded at that edge.
- The result is consumed when `valid_o && ready_i`. If no new accept happens in the same cycle, `valid_o` clears.
- Back-to-back operation: accept and consume in the same cycle loads the new result and `valid_o` stays 1.
- While `valid_o && !ready_i`, `result_o` and `rd_o` are held stable.
- Flush has priority over everything else:
  - `valid_o` is cleared at the next edge.
  - The FSM returns to IDLE.
  - No accept occurs in the flush cycle.
  - `result_o`/`rd_o` keep their values; they are don't-care while `valid_o` = 0.
- x0: `rd_o` = 0 is passed through unchanged; write suppression for x0 is done downstream.

## Timing
- Reset values: `valid_o`=0, `result_o`=0, `rd_o`=0, `busy_o`=0, FSM=IDLE. Reset mid-shift aborts the shift immediately and asynchronously.
- Single-cycle ops: latency 1. Throughput 1 per cycle when `ready_i` is held high.
- Serial shift FSM (only with the feature compiled in):
  - IDLE → SHIFT on accept of op 001 or 101 with shamt ≠ 0. Operand, count = shamt, direction, arithmetic flag and `rd` are latched; `busy_o`=1.
  - SHIFT: each cycle, shift the latched operand by one bit and decrement the count.
  - In the cycle the count reaches 0, load the output register, set `valid_o`=1 and return to IDLE; `busy_o`=0 from the following cycle.
  - The output register is guaranteed free at that edge, because accept required `!valid_o || ready_i` and no further accept can occur in SHIFT. Back-pressure therefore never stalls the shifter.
  - Shift latency is shamt + 1 cycles. A shift with shamt = 0 behaves as a single-cycle op.
  - `ready_o` is 0 throughout SHIFT.

## Configuration
- `EXSTAGE_SERIAL_SHIFT_EN`
  - Defined: shifts use the serial FSM described above.
  - Undefined: shifts are single-cycle via a barrel shifter, `busy_o` is tied to 0, and no SHIFT state exists.
- All other behaviour is identical in both builds.

## Test plan
- Reset during activity: assert `rst_ni`=0 mid-transfer → `valid_o`=0, `result_o`=0, `rd_o`=0, `busy_o`=0 asynchronously; `ready_o`=1 after release.
- Op coverage, XLEN=32:
  - ADD 0x7FFFFFFF+1 → 0x80000000.
  - SUB 0−1 → 0xFFFFFFFF.
  - SLT 0xFFFFFFFF,1 → 1; SLTU 0xFFFFFFFF,1 → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLL by operand2 = 0x21 → shift by 1.
- Back-pressure: two accepted ops with `ready_i`=0 for 3 cycles → second op not accepted (`ready_o`=0); first result and `rd_o` stable; on `ready_i`=1 both results delivered in order, one per cycle.
- Streaming: 8 ADDs with `valid_i`=`ready_i`=1 → 8 results on consecutive cycles, latency 1.
- Serial shift (macro defined): SLL 0x1 by 31, `rd`=5 → `busy_o` high; `valid_o` rises 32 cycles after accept with 0x80000000, `rd_o`=5. Shamt 0 → latency 1. Without the macro → latency 1.
- Flush: `flush_i` asserted while `valid_o`=1 and during SHIFT → `valid_o`=0 and FSM in IDLE next cycle; the `valid_i` offered in the flush cycle is not accepted.
